temp_sensor_reader: RTL

Producer side of the thermostat's 5-bit temperature bus. Periodically reads an 8-bit unsigned temperature (°C) from an external serial sensor over a 3-wire SPI-style link (cs_n, sclk, miso; mode 0, MSB first). It saturates the reading to 5 bits and presents it on `temperature` with a one-cycle `temp_valid` strobe. The block sits between the board sensor pins and the heating/cooling controller.

---
 rtl/temp_sensor_reader.sv | 131 +++++++++++++
 1 files changed

// File: rtl/temp_sensor_reader.sv
// Periodic reader for an 8-bit serial (SPI mode 0) temperature sensor.
// Saturates each reading to 5 bits and strobes temp_valid when it updates.
module temp_sensor_reader #(
    parameter int CLK_DIV     = 4,
    parameter int POLL_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       sensor_miso,
    output logic       sensor_cs_n,
    output logic       sensor_sclk,
    output logic [4:0] temperature,
    output logic       temp_valid,
    output logic       overrange,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        UPDATE
    } state_t;

    localparam int PW = $clog2(POLL_CYCLES);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [4:0]    TEMP_INIT = 5'd20;

    state_t          state;
    logic [PW-1:0]   poll_cnt;
    logic [DW-1:0]   div_cnt;
    logic [3:0]      rise_cnt;
    logic [7:0]      raw;
    logic            div_done;
    logic            trigger;

    assign div_done = (div_cnt == DIV_LAST);
    assign trigger  = start || (poll_cnt == POLL_LAST);

    // Every phase of the transfer is paced by div_cnt; one tick is one sclk half-period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            poll_cnt    <= '0;
            div_cnt     <= '0;
            rise_cnt    <= '0;
            raw         <= '0;
            sensor_cs_n <= 1'b1;
            sensor_sclk <= 1'b0;
            temperature <= TEMP_INIT;
            temp_valid  <= 1'b0;
            overrange   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            temp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        poll_cnt    <= '0;
                        div_cnt     <= '0;
                        sensor_cs_n <= 1'b0;
                        busy        <= 1'b1;
                        state       <= SETUP;
                    end else begin
                        poll_cnt <= poll_cnt + PW'(1);
                        busy     <= 1'b0;
                    end
                end

                SETUP: begin
                    if (div_done) begin
                        div_cnt     <= '0;
                        sensor_sclk <= 1'b1;
                        raw         <= {raw[6:0], sensor_miso};
                        rise_cnt    <= 4'd1;
                        state       <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end

                SHIFT: begin
                    if (div_done) begin
                        div_cnt     <= '0;
                        sensor_sclk <= ~sensor_sclk;
                        // Sample on the same clk edge that drives sclk high.
                        if (!sensor_sclk) begin
                            raw      <= {raw[6:0], sensor_miso};
                            rise_cnt <= rise_cnt + 4'd1;
                        end else if (rise_cnt == 4'd8) begin
                            state <= HOLD;
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end

                HOLD: begin
                    if (div_done) begin
                        div_cnt     <= '0;
                        sensor_cs_n <= 1'b1;
                        state       <= UPDATE;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end

                UPDATE: begin
                    if (raw > 8'd31) begin
                        temperature <= 5'd31;
                        overrange   <= 1'b1;
                    end else begin
                        temperature <= raw[4:0];
                        overrange   <= 1'b0;
                    end
                    temp_valid <= 1'b1;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
